// File: rtl/pipe_mux.sv
// pipe_mux: N-way data select into a two-entry skid-buffered valid/ready pipeline stage.
// Define PIPE_MUX_ERR_CNT_EN to build the saturating out-of-range beat counter on err_cnt.
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [7:0]              err_cnt,
  input  logic                    err_clr
);
  logic             r_main_v, r_main_e, r_skid_v, r_skid_e;
  logic [WIDTH-1:0] r_main_d, r_skid_d;
  logic [WIDTH-1:0] w_data;
  logic             w_err, w_acc, w_drain;
  // Out-of-range selects never match a k, leaving zero data and the error flag set
  always_comb begin
    w_data = '0;
    w_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_data = in_data[k*WIDTH +: WIDTH];
        w_err  = 1'b0;
      end
    end
  end
  assign in_ready  = ~r_skid_v;
  assign w_acc     = in_valid & ~r_skid_v;
  assign w_drain   = r_main_v & out_ready;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;
  assign out_err   = r_main_e;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_main_e <= 1'b0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
      r_skid_e <= 1'b0;
    end else if (w_drain || !r_main_v) begin
      if (r_skid_v) begin
        r_main_v <= 1'b1;
        r_main_d <= r_skid_d;
        r_main_e <= r_skid_e;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_acc;
        if (w_acc) begin
          r_main_d <= w_data;
          r_main_e <= w_err;
        end
      end
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid_d <= w_data;
      r_skid_e <= w_err;
    end
  end
`ifdef PIPE_MUX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else if (err_clr) r_err_cnt <= '0;
    else if (w_acc && w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = err_clr;
  assign err_cnt      = '0;
`endif
endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: drives a 4-input and a 3-input pipe_mux with identical stimulus and checks both
// against a queue-based two-entry FIFO model with a saturating error count.
module tb_pipe_mux;
`ifdef PIPE_MUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct packed {logic [31:0] d; logic e;} beat_t;
  logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] in_data = '0;
  logic         ir[2], ov[2], oe[2];
  logic [31:0]  od[2];
  logic [7:0]   ec[2];
  beat_t        q[2][$];
  int           cnt[2];
  int           checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .sel(sel), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_err(oe[0]), .err_cnt(ec[0]), .err_clr(err_clr));
  pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .sel(sel), .in_data(in_data[95:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_err(oe[1]), .err_cnt(ec[1]), .err_clr(err_clr));

  function automatic logic [127:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one clock and update the reference: a FIFO of depth two, ready whenever not full
  task automatic tick();
    beat_t b;
    bit    acc;
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        q[j].delete();
        cnt[j] = 0;
      end else begin
        acc = in_valid && q[j].size() < 2;
        b.d = 32'd0;
        b.e = 1'b1;
        if (int'(sel) < (j == 0 ? 4 : 3)) begin
          b.d = in_data[int'(sel)*32 +: 32];
          b.e = 1'b0;
        end
        if (q[j].size() > 0 && out_ready) void'(q[j].pop_front());
        if (acc) q[j].push_back(b);
        if (err_clr) cnt[j] = 0;
        else if (acc && b.e && cnt[j] < 255) cnt[j]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      checks++; if (ov[j] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", j, ov[j]); end
      checks++; if (ir[j] !== 1'b1) begin failures++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", j, ir[j]); end
      checks++; if (od[j] !== 32'd0) begin failures++; $display("FAIL reset_out_data dut%0d got=%h exp=0", j, od[j]); end
      checks++; if (oe[j] !== 1'b0) begin failures++; $display("FAIL reset_out_err dut%0d got=%b exp=0", j, oe[j]); end
      checks++; if (ec[j] !== 8'd0) begin failures++; $display("FAIL reset_err_cnt dut%0d got=%0d exp=0", j, ec[j]); end
    end
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single();
    in_data = rnd_data();
    in_data[95:64] = 32'hDEADBEEF;
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%b exp=0", ov[0]); end
    tick();
    in_valid = 1'b0;
    in_data = rnd_data();
    for (int j = 0; j < 2; j++) begin
      checks++; if (ov[j] !== 1'b1) begin failures++; $display("FAIL single_valid dut%0d got=%b exp=1", j, ov[j]); end
      checks++; if (od[j] !== 32'hDEADBEEF || oe[j] !== 1'b0) begin failures++; $display("FAIL single_data dut%0d got=%h/%b exp=deadbeef/0", j, od[j], oe[j]); end
    end
    tick();
    checks++; if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin failures++; $display("FAIL single_drained got=%b%b exp=00", ov[0], ov[1]); end
  endtask

  task automatic test_err();
    in_data = {4{32'h11}};
    sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (od[1] !== 32'd0 || oe[1] !== 1'b1) begin failures++; $display("FAIL err_beat3 got=%h/%b exp=0/1", od[1], oe[1]); end
    checks++; if (od[0] !== 32'h11 || oe[0] !== 1'b0) begin failures++; $display("FAIL err_beat4 got=%h/%b exp=11/0", od[0], oe[0]); end
    checks++; if (ec[1] !== (CNT_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL err_cnt_one got=%0d exp=%0d", ec[1], CNT_EN ? 1 : 0); end
    in_valid = 1'b1;
    repeat (299) tick();
    checks++; if (ec[1] !== (CNT_EN ? 8'd255 : 8'd0)) begin failures++; $display("FAIL err_cnt_sat got=%0d exp=%0d", ec[1], CNT_EN ? 255 : 0); end
    checks++; if (ec[0] !== 8'd0) begin failures++; $display("FAIL err_cnt_inrange got=%0d exp=0", ec[0]); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (ec[1] !== 8'd0) begin failures++; $display("FAIL err_clr_wins got=%0d exp=0", ec[1]); end
    tick();
    in_valid = 1'b0;
    checks++; if (ec[1] !== (CNT_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL err_cnt_after_clr got=%0d exp=%0d", ec[1], CNT_EN ? 1 : 0); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    in_data = rnd_data(); in_data[31:0] = 32'h1;
    tick();
    in_data = rnd_data(); in_data[31:0] = 32'h2;
    tick();
    in_data = rnd_data(); in_data[31:0] = 32'h3;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ir[0] !== 1'b0 || ir[1] !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got=%b%b exp=00", i, ir[0], ir[1]); end
      checks++; if (ov[0] !== 1'b1 || od[0] !== 32'h1) begin failures++; $display("FAIL bp_hold cyc%0d got=%b/%h exp=1/1", i, ov[0], od[0]); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (od[0] !== 32'h2 || ov[0] !== 1'b1 || ir[0] !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b/%b exp=2/1/1", od[0], ov[0], ir[0]); end
    tick();
    in_valid = 1'b0;
    checks++; if (od[1] !== 32'h3 || ov[1] !== 1'b1) begin failures++; $display("FAIL bp_third got=%h/%b exp=3/1", od[1], ov[1]); end
    tick();
    checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", ov[0]); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sel = 2'(i % 4);
      in_data = rnd_data();
      if (ov[0]) n++;
      tick();
      for (int j = 0; j < 2; j++) begin
        checks++; if (ir[j] !== 1'b1 || ov[j] !== 1'b1) begin failures++; $display("FAIL b2b_flow dut%0d beat%0d got=%b%b exp=11", j, i, ir[j], ov[j]); end
        checks++; if ({od[j], oe[j]} !== q[j][0]) begin failures++; $display("FAIL b2b_data dut%0d beat%0d got=%h/%b exp=%h/%b", j, i, od[j], oe[j], q[j][0].d, q[j][0].e); end
      end
    end
    in_valid = 1'b0;
    if (ov[0]) n++;
    tick();
    checks++; if (n !== 100 || ov[0] !== 1'b0) begin failures++; $display("FAIL b2b_count got=%0d/%b exp=100/0", n, ov[0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom() % 4) != 0;
      out_ready = ($urandom() % 3) != 0;
      err_clr = ($urandom() % 50) == 0;
      sel = 2'($urandom());
      in_data = rnd_data();
      tick();
      for (int j = 0; j < 2; j++) begin
        checks++; if (ir[j] !== (q[j].size() < 2) || ov[j] !== (q[j].size() > 0)) begin failures++; $display("FAIL rnd_flags dut%0d cyc%0d got=%b%b exp=%b%b", j, i, ir[j], ov[j], q[j].size() < 2, q[j].size() > 0); end
        if (q[j].size() > 0) begin
          checks++; if ({od[j], oe[j]} !== q[j][0]) begin failures++; $display("FAIL rnd_data dut%0d cyc%0d got=%h/%b exp=%h/%b", j, i, od[j], oe[j], q[j][0].d, q[j][0].e); end
        end
        checks++; if (ec[j] !== (CNT_EN ? 8'(cnt[j]) : 8'd0)) begin failures++; $display("FAIL rnd_err_cnt dut%0d cyc%0d got=%0d exp=%0d", j, i, ec[j], CNT_EN ? cnt[j] : 0); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    in_data = rnd_data(); in_data[31:0] = 32'hA;
    tick();
    in_data = rnd_data(); in_data[31:0] = 32'hB;
    tick();
    checks++; if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin failures++; $display("FAIL rm_full got=%b%b exp=01", ir[0], ov[0]); end
    #2 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      checks++; if (ov[j] !== 1'b0 || ir[j] !== 1'b1) begin failures++; $display("FAIL rm_async dut%0d got=%b%b exp=01", j, ov[j], ir[j]); end
      checks++; if (od[j] !== 32'd0 || oe[j] !== 1'b0 || ec[j] !== 8'd0) begin failures++; $display("FAIL rm_clear dut%0d got=%h/%b/%0d exp=0/0/0", j, od[j], oe[j], ec[j]); end
    end
    tick();
    checks++; if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin failures++; $display("FAIL rm_no_transfer got=%b%b exp=00", ov[0], ov[1]); end
    @(negedge clk) rst_n = 1'b1;
    in_data = rnd_data(); in_data[31:0] = 32'h77; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (ov[0] !== 1'b1 || od[0] !== 32'h77) begin failures++; $display("FAIL rm_next got=%b/%h exp=1/77", ov[0], od[0]); end
    tick();
    checks++; if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin failures++; $display("FAIL rm_alone got=%b%b exp=00", ov[0], ov[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_err();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every input and of the output, range 1..64.
REQ-002 Parameter NUM_IN, default 4, number of selectable inputs, range 2..16.
REQ-003 Parameter SEL_W, default 2, select width, SHALL equal $clog2(NUM_IN), minimum 1.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 sel  input  SEL_W  input index for the current beat.
REQ-009 in_data  input  NUM_IN*WIDTH  flattened inputs, input k at bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_ready  input  1  downstream accepts output beat.
REQ-012 out_data  output  WIDTH  selected data of the current output beat.
REQ-013 out_err  output  1  current output beat came from an out-of-range sel.
REQ-014 err_cnt  output  8  count of out-of-range beats accepted (see Configuration).
REQ-015 err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-016 Input handshake: beat accepted on a rising edge where in_valid=1 and in_ready=1; output handshake: beat drained where out_valid=1 and out_ready=1.
REQ-017 Accepted beat captures in_data[sel] and out_err=0 when sel<NUM_IN; otherwise captures all-zero data and out_err=1.
REQ-018 Storage: two-entry buffer, main register (drives out_*) and skid register; in_ready SHALL equal NOT skid_valid, with no combinational path from out_ready to in_ready.
REQ-019 Latency: a beat accepted into an empty block SHALL appear on out_valid/out_data exactly one cycle later.
REQ-020 Main empty, or main drained this cycle with skid empty: accepted beat loads main.
REQ-021 Main full and not drained: accepted beat loads skid; in_ready falls next cycle.
REQ-022 Main drained while skid full: skid moves to main, skid empties, in_ready rises next cycle; no accept possible that cycle.
REQ-023 Main full, not drained: out_valid, out_data, out_err held stable until drained.
REQ-024 Order SHALL be preserved; no beat dropped or duplicated; simultaneous accept and drain each cycle sustains one beat per cycle.
REQ-025 in_data and sel are sampled only on accept; changes while in_valid=0 or in_ready=0 have no effect.

Reset
REQ-026 rst_n low SHALL immediately clear main and skid valids: out_valid=0, out_data=0, out_err=0, err_cnt=0, in_ready=1.
REQ-027 No transfer occurs while rst_n is low; beats held at assertion are discarded.
REQ-028 Reset release is synchronous to clk by the integrator; first accept possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro PIPE_MUX_ERR_CNT_EN defined: err_cnt increments by 1 per accepted out-of-range beat, saturates at 255, err_clr=1 sets it to 0 next edge (clear wins over simultaneous increment).
REQ-030 Macro undefined: err_cnt tied to 0, err_clr ignored, counter logic absent; out_err behaviour unchanged.

Verification
REQ-031 NUM_IN=4, sel=2, in_data input2=0xDEADBEEF, out_ready=1, one beat -> out_valid=1, out_data=0xDEADBEEF, out_err=0 one cycle after accept.
REQ-032 NUM_IN=3, sel=3, input values 0x11 -> out_data=0x0, out_err=1; with macro err_cnt=1; 300 such beats -> err_cnt=255; err_clr pulse -> 0.
REQ-033 out_ready=0, push beats A=0x1, B=0x2 -> in_ready=0 after B; C held; raise out_ready -> outputs 0x1,0x2,0x3 in order, none lost.
REQ-034 Continuous in_valid=1, out_ready=1, 100 beats with sel cycling 0..3 -> 100 outputs back-to-back, one per cycle, matching model.
REQ-035 Both entries full, assert rst_n=0 mid-cycle -> out_valid=0, in_ready=1 immediately without a clock edge; after release next beat emerges alone.
